// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// One access per three cycles (IDLE -> ACCESS -> RESP); all memory-side outputs are registered.
module dmem_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r1_req,
    input  logic              r0_we,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r0_gnt,
    output logic              r1_gnt,
    output logic              r0_ack,
    output logic              r1_ack,
    output logic [DATA_W-1:0] r0_rdata,
    output logic [DATA_W-1:0] r1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t r_state;
    state_t w_next;

    logic              r_last_r1;
    logic              r_gnt0, r_gnt1;
    logic              r_ack0, r_ack1;
    logic              r_mem_read, r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_rdata0, r_rdata1;

    logic              w_start, w_finish, w_pick_r1, w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (r0_req || r1_req) w_next = ACCESS;
            ACCESS:  w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // On a tie the requester that was not granted last wins; a lone request always wins.
    assign w_pick_r1 = r1_req && (!r0_req || !r_last_r1);
    assign w_start   = (r_state == IDLE) && (r0_req || r1_req);
    assign w_finish  = (r_state == ACCESS);
    assign w_we      = w_pick_r1 ? r1_we    : r0_we;
    assign w_addr    = w_pick_r1 ? r1_addr  : r0_addr;
    assign w_wdata   = w_pick_r1 ? r1_wdata : r0_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_r1   <= 1'b1;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
        end else if (w_start) begin
            r_last_r1   <= w_pick_r1;
            r_gnt0      <= !w_pick_r1;
            r_gnt1      <= w_pick_r1;
            r_mem_read  <= !w_we;
            r_mem_write <= w_we;
            r_mem_addr  <= w_addr;
            r_mem_wdata <= w_wdata;
        end else if (w_finish) begin
            // Memory-side registers return to zero so they are only non-zero during ACCESS.
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_ack0      <= r_gnt0;
            r_ack1      <= r_gnt1;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            if (r_mem_read && r_gnt0) r_rdata0 <= mem_rdata;
            if (r_mem_read && r_gnt1) r_rdata1 <= mem_rdata;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
        end
    end

    assign r0_gnt    = r_gnt0;
    assign r1_gnt    = r_gnt1;
    assign r0_ack    = r_ack0;
    assign r1_ack    = r_ack1;
    assign r0_rdata  = r_rdata0;
    assign r1_rdata  = r_rdata1;
    assign mem_addr  = r_mem_addr;
    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboarded bench for dmem_arbiter: directed requests push expected acks, a monitor pops them.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        r0_req, r1_req, r0_we, r1_we;
    logic [8:0]  r0_addr, r1_addr;
    logic [31:0] r0_wdata, r1_wdata;
    logic        r0_gnt, r1_gnt, r0_ack, r1_ack;
    logic [31:0] r0_rdata, r1_rdata;
    logic [8:0]  mem_addr;
    logic        mem_read, mem_write;
    logic [31:0] mem_wdata, mem_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          who;
        bit          rd;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    dmem_arbiter #(.ADDR_W(9), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r1_req(r1_req), .r0_we(r0_we), .r1_we(r1_we),
        .r0_addr(r0_addr), .r1_addr(r1_addr), .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
        .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_ack(r0_ack), .r1_ack(r1_ack),
        .r0_rdata(r0_rdata), .r1_rdata(r1_rdata),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory model: unwritten words read back as 0xA000_0000 | address.
    logic [31:0] mem_q  [512];
    bit          mem_wr [512];
    always @(posedge clk) begin
        if (mem_write) begin
            mem_q[mem_addr]  <= mem_wdata;
            mem_wr[mem_addr] <= 1'b1;
        end
    end
    assign mem_rdata = mem_wr[mem_addr] ? mem_q[mem_addr] : (32'hA000_0000 | {23'b0, mem_addr});

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mem_read || mem_write) begin
            check("strobe_excl", {31'b0, mem_read & mem_write}, 32'd0);
            check("gnt_onehot", {31'b0, r0_gnt ^ r1_gnt}, 32'd1);
        end
        if (r0_ack || r1_ack) begin
            check("ack_single", {31'b0, r0_ack & r1_ack}, 32'd0);
            check("ack_expected", (sb.size() != 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("ack_who", r1_ack ? 32'd1 : 32'd0, e.who);
                if (e.rd) check("ack_rdata", r1_ack ? r1_rdata : r0_rdata, e.data);
            end
        end
    end

    task automatic drive(input int who, input logic req, input logic we,
                         input logic [8:0] a, input logic [31:0] d);
        if (who == 0) begin
            r0_req = req; r0_we = we; r0_addr = a; r0_wdata = d;
        end else begin
            r1_req = req; r1_we = we; r1_addr = a; r1_wdata = d;
        end
    endtask

    task automatic drop(input int who);
        if (who == 0) r0_req = 1'b0;
        else          r1_req = 1'b0;
    endtask

    task automatic wait_ack(input int who, input string name, input bit do_drop);
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = (who == 0) ? r0_ack : r1_ack;
        end
        check(name, {31'b0, got}, 32'd1);
        @(posedge clk);
        #1;
        if (do_drop) drop(who);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, '0, '0);
        drive(1, 0, 0, '0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_gnt", {30'b0, r0_gnt, r1_gnt}, 0);
        check("rst_ack", {30'b0, r0_ack, r1_ack}, 0);
        check("rst_strobes", {30'b0, mem_read, mem_write}, 0);
        check("rst_mem_addr", {23'b0, mem_addr}, 0);
        check("rst_rdata0", r0_rdata, 0);
        check("rst_rdata1", r1_rdata, 0);
        reset = 1'b1;

        // r0 write 0x005 <- DEADBEEF, cycle-exact
        sb.push_back('{0, 1'b0, 32'h0});
        drive(0, 1, 1, 9'h005, 32'hDEADBEEF);
        @(posedge clk);
        @(negedge clk);
        check("acc_mem_write", {31'b0, mem_write}, 1);
        check("acc_mem_read", {31'b0, mem_read}, 0);
        check("acc_mem_addr", {23'b0, mem_addr}, 32'h005);
        check("acc_mem_wdata", mem_wdata, 32'hDEADBEEF);
        check("acc_r0_gnt", {31'b0, r0_gnt}, 1);
        check("acc_busy", {31'b0, busy}, 1);
        check("acc_r0_ack", {31'b0, r0_ack}, 0);
        @(negedge clk);
        check("resp_r0_ack", {31'b0, r0_ack}, 1);
        check("resp_mem_write", {31'b0, mem_write}, 0);
        check("resp_mem_addr", {23'b0, mem_addr}, 0);
        check("resp_mem_wdata", mem_wdata, 0);
        check("resp_r0_gnt", {31'b0, r0_gnt}, 0);
        check("resp_busy", {31'b0, busy}, 1);
        @(posedge clk);
        #1 drop(0);
        @(negedge clk);
        check("idle_busy", {31'b0, busy}, 0);
        check("idle_r0_ack", {31'b0, r0_ack}, 0);

        // r1 reads back the word r0 wrote
        sb.push_back('{1, 1'b1, 32'hDEADBEEF});
        drive(1, 1, 0, 9'h005, '0);
        wait_ack(1, "r1_read_ack", 1);
        check("r0_rdata_unchanged", r0_rdata, 0);
        check("r1_rdata_hold", r1_rdata, 32'hDEADBEEF);

        // Two ties: r0 wins first (last grant was r1), then alternation r0,r1,r0,r1
        sb.push_back('{0, 1'b1, 32'hA000_0010});
        sb.push_back('{1, 1'b1, 32'hA000_0020});
        drive(0, 1, 0, 9'h010, '0);
        drive(1, 1, 0, 9'h020, '0);
        wait_ack(0, "tie1_r0_ack", 1);
        wait_ack(1, "tie1_r1_ack", 1);
        sb.push_back('{0, 1'b1, 32'hA000_0011});
        sb.push_back('{1, 1'b1, 32'hA000_0021});
        drive(0, 1, 0, 9'h011, '0);
        drive(1, 1, 0, 9'h021, '0);
        wait_ack(0, "tie2_r0_ack", 1);
        wait_ack(1, "tie2_r1_ack", 1);

        // r0 holds req continuously; r1 arrives during r0's access and must be next
        sb.push_back('{0, 1'b1, 32'hA000_0013});
        sb.push_back('{1, 1'b1, 32'hA000_0022});
        sb.push_back('{0, 1'b1, 32'hA000_0013});
        drive(0, 1, 0, 9'h013, '0);
        @(posedge clk);
        #1 drive(1, 1, 0, 9'h022, '0);
        wait_ack(0, "hog_r0_ack1", 0);
        wait_ack(1, "starve_r1_ack", 1);
        wait_ack(0, "hog_r0_ack2", 1);

        // Reset in the middle of an r1 write aborts it without an ack
        drive(1, 1, 1, 9'h030, 32'h0000_1234);
        @(posedge clk);
        @(negedge clk);
        check("abort_pre_write", {31'b0, mem_write}, 1);
        check("abort_pre_gnt", {31'b0, r1_gnt}, 1);
        #2 reset = 1'b0;
        #1;
        check("abort_mem_write", {31'b0, mem_write}, 0);
        check("abort_r1_gnt", {31'b0, r1_gnt}, 0);
        check("abort_busy", {31'b0, busy}, 0);
        check("abort_mem_addr", {23'b0, mem_addr}, 0);
        check("abort_rdata0", r0_rdata, 0);
        check("abort_rdata1", r1_rdata, 0);
        drop(1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        // Tie after reset goes to r0; the aborted write must not have reached memory
        sb.push_back('{0, 1'b1, 32'hA000_0030});
        sb.push_back('{1, 1'b1, 32'hA000_0031});
        drive(0, 1, 0, 9'h030, '0);
        drive(1, 1, 0, 9'h031, '0);
        wait_ack(0, "post_rst_r0_ack", 1);
        wait_ack(1, "post_rst_r1_ack", 1);

        // r0 drops req during ACCESS; the access still completes
        sb.push_back('{0, 1'b1, 32'hA000_0012});
        drive(0, 1, 0, 9'h012, '0);
        @(posedge clk);
        #1 drop(0);
        wait_ack(0, "dropped_req_ack", 1);
        @(negedge clk);
        check("dropped_busy", {31'b0, busy}, 0);
        check("dropped_r0_ack", {31'b0, r0_ack}, 0);

        // Top address; a write leaves rdata registers alone
        sb.push_back('{1, 1'b0, 32'h0});
        drive(1, 1, 1, 9'h1FF, 32'h1234_5678);
        wait_ack(1, "top_write_ack", 1);
        check("write_keeps_r1_rdata", r1_rdata, 32'hA000_0031);
        sb.push_back('{0, 1'b1, 32'h1234_5678});
        drive(0, 1, 0, 9'h1FF, '0);
        wait_ack(0, "top_read_ack", 1);

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 9, memory word address width.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 r0_req, r1_req  input  1 each  access request from requester 0 / 1.
REQ-006 r0_we, r1_we  input  1 each  1 = write, 0 = read.
REQ-007 r0_addr, r1_addr  input  ADDR_W each  word address.
REQ-008 r0_wdata, r1_wdata  input  DATA_W each  write data.
REQ-009 r0_gnt, r1_gnt  output  1 each  access in progress for that requester.
REQ-010 r0_ack, r1_ack  output  1 each  one-cycle completion pulse.
REQ-011 r0_rdata, r1_rdata  output  DATA_W each  read result, valid while matching ack is high.
REQ-012 mem_addr  output  ADDR_W  address to data memory.
REQ-013 mem_read, mem_write  output  1 each  data memory strobes.
REQ-014 mem_wdata  output  DATA_W  write data to memory.
REQ-015 mem_rdata  input  DATA_W  combinational read data from memory.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 FSM states: IDLE, ACCESS, RESP; IDLE->ACCESS when any req high at the edge; ACCESS->RESP unconditionally; RESP->IDLE unconditionally.
REQ-018 Latency: request sampled at edge E; gnt and memory strobes high in cycle E..E+1; ack high in cycle E+1..E+2; one access per 3 cycles minimum.
REQ-019 On the IDLE->ACCESS edge, winner's we/addr/wdata SHALL be captured into internal registers; mem_* outputs driven only from these registers.
REQ-020 mem_read (read) or mem_write (write) high for exactly the ACCESS cycle; both never high together; both 0 in IDLE and RESP.
REQ-021 mem_addr and mem_wdata SHALL be 0 outside ACCESS and glitch-free (registered) during ACCESS, since the memory write is level-sensitive.
REQ-022 Arbitration round-robin: single request wins; on simultaneous requests, the requester not granted last wins; last-grant pointer updates on every grant.
REQ-023 Exactly one gnt high during ACCESS; gnt SHALL drop in RESP.
REQ-024 On the ACCESS->RESP edge, a read captures mem_rdata into the winner's rdata register; a write leaves both rdata registers unchanged.
REQ-025 ack pulses for exactly the RESP cycle, only to the winner.
REQ-026 Requester SHALL hold req/we/addr/wdata stable until ack and drop req at the edge sampling ack; a req still high in the IDLE cycle after RESP is a new request.
REQ-027 req deasserted during ACCESS or RESP is ignored; the access completes and ack is still issued.
REQ-028 Requests arriving during ACCESS or RESP are not sampled until IDLE; the loser's req stays pending and wins next (REQ-022).
REQ-029 rdata registers hold value between accesses; readable anytime.

Reset
REQ-030 reset low SHALL immediately force state IDLE, all gnt/ack/mem_read/mem_write/busy 0, mem_addr/mem_wdata 0, rdata registers 0, last-grant pointer to requester 1 (requester 0 wins first tie).
REQ-031 reset asserted during ACCESS aborts the access with no ack; strobes drop asynchronously.
REQ-032 First request sampled at the first rising edge after reset deasserts.

Verification
REQ-033 Reset, r0 write addr 0x005 data 0xDEADBEEF -> mem_write high 1 cycle with mem_addr 0x005, r0_ack next cycle, r1_ack never.
REQ-034 r1 read addr 0x005 after REQ-033 -> mem_read 1 cycle, r1_ack with r1_rdata 0xDEADBEEF; r0_rdata unchanged (0).
REQ-035 r0 and r1 request same edge after reset -> r0 granted first, r1 granted at next IDLE edge; repeated 4x -> grants alternate r0,r1,r0,r1.
REQ-036 r0 holds req continuously, r1 requests once -> r1 served within 2 grants (no starvation).
REQ-037 reset low mid-ACCESS of r1 write 0x0000_1234 -> mem_write, r1_gnt, busy drop immediately; no r1_ack; after release, r0 wins a tie.
REQ-038 r0 drops req during ACCESS -> r0_ack still pulses in RESP; FSM back to IDLE, busy 0.
